z_sigmoid: RTL and testbench

//  Activation stage directly downstream of the z accumulator: takes each finished z (signed fixed point)
//  and produces sigmoid(z) by a shift-and-add piecewise-linear (PLAN) approximation, with no multiplier.
//  3-stage pipeline with valid/ready handshake on both sides; tags each result with its neuron index
//  and flags the last neuron of a layer so the layer sequencer can swap BRAM banks.

---
 rtl/z_sigmoid_pkg.sv | 21 ++
 rtl/sigmoid_pwl_seg.sv | 55 +++++
 rtl/z_sigmoid.sv | 124 ++++++++++++
 tb/tb_z_sigmoid.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z_sigmoid_pkg.sv
// Shared fixed-point constants and region encoding for the sigmoid activation stage.
package z_sigmoid_pkg;

    localparam int unsigned FRAC = 16;

    // Q-format constants; 1.0 = 1 << FRAC
    localparam int unsigned ONE    = 1 << FRAC;
    localparam int unsigned HALF   = 1 << (FRAC - 1);
    localparam int unsigned C_R0   = HALF;
    localparam int unsigned C_R1   = 5 << (FRAC - 3);
    localparam int unsigned C_R2   = 27 << (FRAC - 5);
    localparam int unsigned BP1    = ONE;
    localparam int unsigned BP2375 = 19 << (FRAC - 3);
    localparam int unsigned BP5    = 5 << FRAC;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

endpackage

// File: rtl/sigmoid_pwl_seg.sv
// Combinational PLAN helpers: |z| with saturation plus region decode, and the shift-add segment value.
module sigmoid_pwl_seg
    import z_sigmoid_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] z_i,
    output logic [DWIDTH-1:0] abs_c,
    output logic              sign_c,
    output logic [1:0]        region_c,
    input  logic [DWIDTH-1:0] a_i,
    input  logic [1:0]        region_i,
    output logic [DWIDTH-1:0] y_c
);

    localparam logic [DWIDTH-1:0] MIN_Z    = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] MAX_A    = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] K_ONE    = DWIDTH'(ONE);
    localparam logic [DWIDTH-1:0] K_C_R0   = DWIDTH'(C_R0);
    localparam logic [DWIDTH-1:0] K_C_R1   = DWIDTH'(C_R1);
    localparam logic [DWIDTH-1:0] K_C_R2   = DWIDTH'(C_R2);
    localparam logic [DWIDTH-1:0] K_BP1    = DWIDTH'(BP1);
    localparam logic [DWIDTH-1:0] K_BP2375 = DWIDTH'(BP2375);
    localparam logic [DWIDTH-1:0] K_BP5    = DWIDTH'(BP5);

    // Most-negative z has no positive twin, so clamp it to the largest magnitude
    always_comb begin
        sign_c   = z_i[DWIDTH-1];
        abs_c    = z_i;
        region_c = R0;
        if (z_i == MIN_Z) begin
            abs_c = MAX_A;
        end else if (sign_c) begin
            abs_c = ~z_i + DWIDTH'(1);
        end
        if (abs_c >= K_BP5) begin
            region_c = R3;
        end else if (abs_c >= K_BP2375) begin
            region_c = R2;
        end else if (abs_c >= K_BP1) begin
            region_c = R1;
        end
    end

    always_comb begin
        y_c = (a_i >> 2) + K_C_R0;
        case (region_i)
            R3:      y_c = K_ONE;
            R2:      y_c = (a_i >> 5) + K_C_R2;
            R1:      y_c = (a_i >> 3) + K_C_R1;
            default: y_c = (a_i >> 2) + K_C_R0;
        endcase
    end

endmodule

// File: rtl/z_sigmoid.sv
// Three-stage sigmoid activation pipeline with valid/ready handshake and per-layer neuron index tagging.
module z_sigmoid
    import z_sigmoid_pkg::*;
#(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned HiddenNeuron = 16,
    parameter int unsigned IDXW         = (HiddenNeuron > 1) ? $clog2(HiddenNeuron) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_act,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last
);

    localparam logic [DWIDTH-1:0] K_ONE    = DWIDTH'(ONE);
    localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(HiddenNeuron - 1);

    logic              s1_vld_q, s1_vld_d;
    logic              s1_sign_q, s1_sign_d;
    logic [1:0]        s1_region_q, s1_region_d;
    logic [DWIDTH-1:0] s1_abs_q, s1_abs_d;
    logic              s2_vld_q, s2_vld_d;
    logic              s2_sign_q, s2_sign_d;
    logic [DWIDTH-1:0] s2_y_q, s2_y_d;
    logic              out_vld_q, out_vld_d;
    logic [DWIDTH-1:0] act_q, act_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              last_q, last_d;

    logic              advance_c;
    logic [DWIDTH-1:0] abs_c;
    logic              sign_c;
    logic [1:0]        region_c;
    logic [DWIDTH-1:0] y_c;

    sigmoid_pwl_seg #(.DWIDTH(DWIDTH)) u_seg (
        .z_i      (in_z),
        .abs_c    (abs_c),
        .sign_c   (sign_c),
        .region_c (region_c),
        .a_i      (s1_abs_q),
        .region_i (s1_region_q),
        .y_c      (y_c)
    );

    assign advance_c = !out_vld_q || out_ready;
    assign in_ready  = advance_c && !flush;
    assign out_valid = out_vld_q;
    assign out_act   = act_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

    // Whole pipeline advances together; flush overrides any transfer this cycle
    always_comb begin
        s1_vld_d    = s1_vld_q;
        s1_sign_d   = s1_sign_q;
        s1_region_d = s1_region_q;
        s1_abs_d    = s1_abs_q;
        s2_vld_d    = s2_vld_q;
        s2_sign_d   = s2_sign_q;
        s2_y_d      = s2_y_q;
        out_vld_d   = out_vld_q;
        act_d       = act_q;
        idx_d       = idx_q;
        last_d      = last_q;
        if (flush) begin
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            out_vld_d = 1'b0;
            idx_d     = '0;
            last_d    = 1'b0;
        end else if (advance_c) begin
            s1_vld_d    = in_valid;
            s1_sign_d   = sign_c;
            s1_region_d = region_c;
            s1_abs_d    = abs_c;
            s2_vld_d    = s1_vld_q;
            s2_sign_d   = s1_sign_q;
            s2_y_d      = y_c;
            out_vld_d   = s2_vld_q;
            act_d       = s2_sign_q ? (K_ONE - s2_y_q) : s2_y_q;
            if (out_vld_q && out_ready) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
            end
            last_d = out_vld_d && (idx_d == IDX_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_region_q <= R0;
            s1_abs_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_y_q      <= '0;
            out_vld_q   <= 1'b0;
            act_q       <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_sign_q   <= s1_sign_d;
            s1_region_q <= s1_region_d;
            s1_abs_q    <= s1_abs_d;
            s2_vld_q    <= s2_vld_d;
            s2_sign_q   <= s2_sign_d;
            s2_y_q      <= s2_y_d;
            out_vld_q   <= out_vld_d;
            act_q       <= act_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_z_sigmoid.sv
// Self-checking bench for z_sigmoid: directed corner values plus randomized traffic against a reference model.
module tb_z_sigmoid;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_act;
    logic [3:0]  out_idx;
    logic        out_last;

    int     n_tests;
    int     n_fail;
    int     n_out;
    int     exp_idx;
    bit     chk_rdy;
    longint sb[$];
    int     idx_log[$];
    bit     last_log[$];

    z_sigmoid #(.DWIDTH(32), .HiddenNeuron(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sigmoid reference straight from the segment table, using plain integer arithmetic
    function automatic longint ref_act(input logic [31:0] z);
        longint zs;
        longint a;
        longint y;
        zs = longint'($signed(z));
        if (zs == -64'sd2147483648) a = 2147483647;
        else                        a = (zs < 0) ? -zs : zs;
        if (a >= 5 * 65536)          y = 65536;
        else if (a >= 155648)        y = a / 32 + 55296;
        else if (a >= 65536)         y = a / 8 + 40960;
        else                         y = a / 4 + 32768;
        return (zs < 0) ? (65536 - y) : y;
    endfunction

    // Scoreboard: observe accepted inputs and delivered outputs at the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            exp_idx = 0;
        end else begin
            if (chk_rdy) check("in_ready", in_ready, (!out_valid || out_ready) && !flush);
            if (flush) begin
                sb.delete();
                exp_idx = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        check("act", out_act, sb.pop_front());
                        check("idx", out_idx, exp_idx);
                        check("last", out_last, exp_idx == 15);
                    end
                    idx_log.push_back(int'(out_idx));
                    last_log.push_back(out_last);
                    n_out++;
                    exp_idx = (exp_idx + 1) % 16;
                end
                if (in_valid && in_ready) sb.push_back(ref_act(in_z));
            end
        end
    end

    task automatic directed(input logic [31:0] z, input longint exp);
        int n;
        in_valid  = 1'b1;
        in_z      = z;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 3);
        check("dir_act", out_act, exp);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic stream(input int count);
        int sent;
        int cyc;
        bit acc;
        sent = 0;
        cyc  = 0;
        out_ready = 1'b1;
        while (sent < count && cyc < 200) begin
            in_valid = 1'b1;
            in_z     = 32'($urandom_range(0, 1200000)) - 32'd600000;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        check("stream_sent", sent, count);
        in_valid = 1'b0;
    endtask

    logic [31:0] vec[20];

    initial begin
        int base;
        int sent;
        int cyc;
        bit acc;
        n_tests = 0; n_fail = 0; n_out = 0; exp_idx = 0; chk_rdy = 1'b0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_z = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_act", out_act, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed corner values including the abs saturation path
        in_valid = 1'b1; in_z = 32'd0; out_ready = 1'b1;
        directed(32'd0, 32768);
        directed(32'd65536, 49152);
        directed(-32'sd65536, 16384);
        directed(32'd196608, 61440);
        directed(-32'sd196608, 4096);
        directed(32'd393216, 65536);
        directed(32'h8000_0000, 0);
        directed(32'd155647, 60415);
        directed(32'd155648, 60160);
        directed(32'd65535, 49151);
        directed(32'd327679, 65535);
        directed(32'd327680, 65536);

        // Back-to-back traffic with a toggling consumer
        vec[0] = 32'd155648;  vec[1] = 32'd155647;  vec[2] = -32'sd327680; vec[3] = 32'h8000_0000;
        vec[4] = 32'h7fff_ffff; vec[5] = -32'sd65536; vec[6] = 32'd1;       vec[7] = -32'sd1;
        for (int i = 8; i < 20; i++) vec[i] = 32'($urandom_range(0, 1200000)) - 32'd600000;
        base = n_out; sent = 0; cyc = 0; chk_rdy = 1'b1;
        while (sent < 20 && cyc < 200) begin
            in_valid  = 1'b1;
            in_z      = vec[sent];
            out_ready = (cyc % 2) == 0;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        check("t4_sent", sent, 20);
        drain();
        chk_rdy = 1'b0;
        check("t4_count", n_out - base, 20);

        // Full layer of 16 plus one wrap
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_idx", out_idx, 0);
        idx_log.delete(); last_log.delete();
        stream(17);
        drain();
        check("t5_count", idx_log.size(), 17);
        if (idx_log.size() == 17) begin
            for (int i = 0; i < 17; i++) begin
                check("t5_idx", idx_log[i], i % 16);
                check("t5_last", last_log[i], i == 15);
            end
        end

        // Reset with two items in flight
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_z     = 32'($urandom_range(0, 400000));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_idx", out_idx, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idx_log.delete(); last_log.delete();
        stream(1);
        drain();
        check("rst_next_cnt", idx_log.size(), 1);
        if (idx_log.size() > 0) check("rst_next_idx", idx_log[0], 0);

        // Flush mid-stream with results already delivered
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_z     = 32'($urandom_range(0, 1200000)) - 32'd600000;
            if (i == 5) flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            if (i == 5) begin
                check("flush_mid_valid", out_valid, 0);
                check("flush_mid_idx", out_idx, 0);
                idx_log.delete(); last_log.delete();
            end
        end
        drain();
        check("flush_next_cnt", idx_log.size(), 2);
        if (idx_log.size() > 0) check("flush_next_idx", idx_log[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
